// File: rtl/hyper_tx_prefetch.sv
// Prefetch feeder for the hyperbus TX linear channel: credit-limited L2 word reads,
// buffered in a first-word-fall-through FIFO and streamed to the macro with byte enables.
module hyper_tx_prefetch #(
    parameter int ADDR_W = 32,
    parameter int SIZE_W = 20,
    parameter int DEPTH  = 8
) (
    input  logic                       sys_clk_i,
    input  logic                       rst_i,
    input  logic                       cfg_start_i,
    input  logic [ADDR_W-1:0]          cfg_addr_i,
    input  logic [SIZE_W-1:0]          cfg_size_i,
    input  logic                       cfg_stop_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       aborted_o,
    output logic                       req_o,
    output logic [ADDR_W-1:0]          req_addr_o,
    input  logic                       req_gnt_i,
    input  logic                       rsp_valid_i,
    input  logic [31:0]                rsp_data_i,
    output logic                       data_valid_o,
    output logic [31:0]                data_o,
    output logic [3:0]                 data_be_o,
    output logic                       data_last_o,
    input  logic                       data_ready_i,
    output logic [$clog2(DEPTH):0]     fifo_level_o
);

    // state | meaning
    // IDLE  | waiting for cfg_start_i, descriptor latched here
    // RUN   | issuing reads and streaming words to the macro
    // FLUSH | aborted, absorbing responses still in flight
    // DONE  | one-cycle done_o pulse, then back to IDLE
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int NW = SIZE_W + 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [NW-1:0]     n_words_q, issued_q, popped_q;
    logic [1:0]        size_lo_q;
    logic              aborted_q;
    logic [LW-1:0]     outstanding_q, level_q;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [31:0]       mem_q [DEPTH];

    logic [NW-1:0]     n_words_cfg;
    logic [LW:0]       credit_sum;
    logic              grant, rsp_ok, push, pop, stop, last_pop;

    assign n_words_cfg = ({1'b0, cfg_size_i} + NW'(3)) >> 2;
    assign credit_sum  = {1'b0, outstanding_q} + {1'b0, level_q};

    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);
    assign aborted_o    = done_o & aborted_q;
    assign req_o        = (state_q == RUN) && (issued_q < n_words_q) && (credit_sum < (LW+1)'(DEPTH));
    assign req_addr_o   = addr_q;
    assign data_valid_o = (state_q == RUN) && (level_q != '0);
    assign data_o       = data_valid_o ? mem_q[rd_ptr_q] : '0;
    assign data_last_o  = data_valid_o && (popped_q == n_words_q - NW'(1));
    assign fifo_level_o = level_q;

    assign grant    = req_o & req_gnt_i;
    // responses with nothing outstanding are protocol errors and are dropped
    assign rsp_ok   = rsp_valid_i && (outstanding_q != '0);
    assign push     = rsp_ok && (state_q == RUN);
    assign pop      = data_valid_o && data_ready_i;
    assign stop     = (state_q == RUN) && cfg_stop_i;
    assign last_pop = pop && (popped_q == n_words_q - NW'(1));

    always_comb begin
        data_be_o = 4'h0;
        if (data_valid_o) begin
            data_be_o = 4'hF;
            if (data_last_o) begin
                case (size_lo_q)
                    2'd1:    data_be_o = 4'h1;
                    2'd2:    data_be_o = 4'h3;
                    2'd3:    data_be_o = 4'h7;
                    default: data_be_o = 4'hF;
                endcase
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_start_i) state_d = (n_words_cfg == '0) ? DONE : RUN;
            RUN:     if (cfg_stop_i) state_d = FLUSH;
                     else if (last_pop) state_d = DONE;
            FLUSH:   if (outstanding_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            n_words_q     <= '0;
            issued_q      <= '0;
            popped_q      <= '0;
            size_lo_q     <= '0;
            aborted_q     <= 1'b0;
            outstanding_q <= '0;
            level_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && cfg_start_i) begin
                addr_q    <= cfg_addr_i & ~ADDR_W'(3);
                n_words_q <= n_words_cfg;
                size_lo_q <= cfg_size_i[1:0];
                issued_q  <= '0;
                popped_q  <= '0;
                aborted_q <= 1'b0;
            end
            if (grant) begin
                addr_q   <= addr_q + ADDR_W'(4);
                issued_q <= issued_q + NW'(1);
            end
            if (grant && !rsp_ok)
                outstanding_q <= outstanding_q + LW'(1);
            else if (!grant && rsp_ok)
                outstanding_q <= outstanding_q - LW'(1);
            if (stop) begin
                aborted_q <= 1'b1;
                level_q   <= '0;
                wr_ptr_q  <= '0;
                rd_ptr_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                    popped_q <= popped_q + NW'(1);
                end
                if (push && !pop)
                    level_q <= level_q + LW'(1);
                else if (pop && !push)
                    level_q <= level_q - LW'(1);
            end
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (push && !stop) mem_q[wr_ptr_q] <= rsp_data_i;
    end

endmodule

// File: tb/tb_hyper_tx_prefetch.sv
// Scoreboard bench for hyper_tx_prefetch: directed descriptors push expected requests,
// words and done events; a negedge monitor pops and compares as the DUT presents them.
module tb_hyper_tx_prefetch;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  be;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        cfg_start_i = 1'b0;
    logic [31:0] cfg_addr_i = '0;
    logic [19:0] cfg_size_i = '0;
    logic        cfg_stop_i = 1'b0;
    logic        busy_o, done_o, aborted_o, req_o;
    logic [31:0] req_addr_o;
    logic        req_gnt_i = 1'b0;
    logic        rsp_valid_i = 1'b0;
    logic [31:0] rsp_data_i = '0;
    logic        data_valid_o;
    logic [31:0] data_o;
    logic [3:0]  data_be_o;
    logic        data_last_o;
    logic        data_ready_i = 1'b0;
    logic [3:0]  fifo_level_o;

    hyper_tx_prefetch #(.ADDR_W(32), .SIZE_W(20), .DEPTH(8)) dut (
        .sys_clk_i(clk), .rst_i(rst_i),
        .cfg_start_i(cfg_start_i), .cfg_addr_i(cfg_addr_i), .cfg_size_i(cfg_size_i),
        .cfg_stop_i(cfg_stop_i), .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o),
        .req_o(req_o), .req_addr_o(req_addr_o), .req_gnt_i(req_gnt_i),
        .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i),
        .data_valid_o(data_valid_o), .data_o(data_o), .data_be_o(data_be_o),
        .data_last_o(data_last_o), .data_ready_i(data_ready_i), .fifo_level_o(fifo_level_o)
    );

    initial forever #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int grant_cnt = 0;
    int done_cnt = 0;
    logic gnt_en = 1'b1;
    logic gnt_alt = 1'b0;

    logic [31:0] exp_req[$];
    exp_t        exp_data[$];
    logic        exp_done[$];
    int          rsp_due[$];
    logic [31:0] rsp_dat[$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC3C3_0F0F;
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // L2 model: grants per gnt_en/gnt_alt, returns data two cycles after each grant
    initial forever begin
        @(posedge clk);
        #2;
        req_gnt_i = gnt_en && (!gnt_alt || cyc[0]);
        if (rsp_due.size() > 0 && rsp_due[0] == cyc) begin
            rsp_valid_i = 1'b1;
            rsp_data_i  = rsp_dat[0];
            void'(rsp_due.pop_front());
            void'(rsp_dat.pop_front());
        end else begin
            rsp_valid_i = 1'b0;
            rsp_data_i  = '0;
        end
    end

    // monitor
    logic        prev_pending = 1'b0;
    logic        prev_skip = 1'b1;
    logic [31:0] prev_addr = '0;
    initial forever begin
        @(negedge clk);
        if (!rst_i) begin
            if (prev_pending && !prev_skip) begin
                chk("req_hold", {req_o, req_addr_o}, {1'b1, prev_addr});
            end
            if (req_o && req_gnt_i) begin
                grant_cnt++;
                rsp_due.push_back(cyc + 2);
                rsp_dat.push_back(word_of(req_addr_o));
                if (exp_req.size() == 0) begin
                    chk("req_unexpected", 64'(req_addr_o), 64'hDEAD_0000_0000);
                end else begin
                    chk("req_addr", 64'(req_addr_o), 64'(exp_req.pop_front()));
                end
            end
            if (data_valid_o && data_ready_i) begin
                if (exp_data.size() == 0) begin
                    chk("data_unexpected", 64'({data_o, data_be_o, data_last_o}), 64'hDEAD_0000_0000_0000);
                end else begin
                    chk("data_word", 64'({data_o, data_be_o, data_last_o}), 64'(exp_data.pop_front()));
                end
            end
            if (done_o) begin
                done_cnt++;
                if (exp_done.size() == 0) begin
                    chk("done_unexpected", 64'(aborted_o), 64'h2);
                end else begin
                    chk("done_aborted", 64'(aborted_o), 64'(exp_done.pop_front()));
                end
            end
        end
        prev_pending = req_o && !req_gnt_i;
        prev_addr    = req_addr_o;
        prev_skip    = rst_i || cfg_stop_i;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [19:0] sz, input int n_req,
                         input int n_data, input logic ab);
        logic [31:0] base;
        int   n;
        exp_t e;
        base = a & 32'hFFFF_FFFC;
        n    = (int'(sz) + 3) / 4;
        for (int i = 0; i < n_req; i++) exp_req.push_back(base + 32'(4 * i));
        for (int i = 0; i < n_data; i++) begin
            e.d    = word_of(base + 32'(4 * i));
            e.last = (i == n - 1);
            e.be   = 4'hF;
            if (i == n - 1) begin
                case (sz[1:0])
                    2'd1:    e.be = 4'h1;
                    2'd2:    e.be = 4'h3;
                    2'd3:    e.be = 4'h7;
                    default: e.be = 4'hF;
                endcase
            end
            exp_data.push_back(e);
        end
        exp_done.push_back(ab);
        cfg_addr_i  = a;
        cfg_size_i  = sz;
        cfg_start_i = 1'b1;
        tick(1);
        cfg_start_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int tgt;
        tgt = done_cnt + 1;
        for (int i = 0; i < budget && done_cnt < tgt; i++) tick(1);
        chk(name, 64'(done_cnt >= tgt), 64'h1);
    endtask

    task automatic check_all_zero(input string name);
        chk(name, {19'd0, busy_o, done_o, aborted_o, req_o, data_valid_o, data_be_o,
                   data_last_o, fifo_level_o, req_addr_o} | 64'(data_o), 64'h0);
    endtask

    initial begin
        int g0;
        tick(3);
        check_all_zero("reset_outputs");
        rst_i = 1'b0;
        data_ready_i = 1'b1;
        tick(2);

        issue(32'h1C00_0000, 20'd16, 4, 4, 1'b0);
        wait_done("done_size16", 20);
        chk("idle_after_16", 64'(busy_o), 64'h0);

        issue(32'h0000_0102, 20'd7, 2, 2, 1'b0);
        wait_done("done_size7", 20);

        issue(32'h0000_0200, 20'd0, 0, 0, 1'b0);
        wait_done("done_size0", 2);
        tick(2);

        data_ready_i = 1'b0;
        g0 = grant_cnt;
        issue(32'h0000_8000, 20'd64, 16, 16, 1'b0);
        tick(20);
        chk("credit_grants", 64'(grant_cnt - g0), 64'd8);
        chk("credit_req_low", 64'(req_o), 64'h0);
        chk("credit_full_level", 64'(fifo_level_o), 64'd8);
        data_ready_i = 1'b1;
        wait_done("done_size64", 80);

        gnt_alt = 1'b1;
        issue(32'hFFFF_FFF8, 20'd16, 4, 4, 1'b0);
        wait_done("done_wrap", 40);
        gnt_alt = 1'b0;

        data_ready_i = 1'b0;
        g0 = grant_cnt;
        issue(32'h0000_2000, 20'd32, 3, 0, 1'b1);
        for (int i = 0; i < 10 && grant_cnt - g0 < 3; i++) tick(1);
        chk("abort_three_grants", 64'(grant_cnt - g0), 64'd3);
        cfg_stop_i = 1'b1;
        gnt_en = 1'b0;
        tick(1);
        cfg_stop_i = 1'b0;
        chk("abort_req_low", 64'(req_o), 64'h0);
        chk("abort_valid_low", 64'(data_valid_o), 64'h0);
        wait_done("done_abort", 10);
        chk("abort_level", 64'(fifo_level_o), 64'h0);
        gnt_en = 1'b1;
        data_ready_i = 1'b1;
        issue(32'h0000_3000, 20'd8, 2, 2, 1'b0);
        wait_done("done_after_abort", 20);

        g0 = done_cnt;
        issue(32'h0000_4000, 20'd32, 8, 8, 1'b0);
        tick(4);
        rst_i = 1'b1;
        tick(1);
        check_all_zero("midrun_reset_outputs");
        rst_i = 1'b0;
        exp_req.delete();
        exp_data.delete();
        exp_done.delete();
        tick(6);
        chk("reset_no_done", 64'(done_cnt - g0), 64'h0);
        chk("reset_late_rsp_dropped", 64'({busy_o, fifo_level_o}), 64'h0);
        issue(32'h0000_5000, 20'd10, 3, 3, 1'b0);
        wait_done("done_after_reset", 20);

        tick(4);
        chk("exp_req_drained", 64'(exp_req.size()), 64'h0);
        chk("exp_data_drained", 64'(exp_data.size()), 64'h0);
        chk("exp_done_drained", 64'(exp_done.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
